// File: rtl/exec_pkg.sv
// Shared encodings for the RV32I execute stage: ALU ops, branch types, forward selects.
// ALU_MUL is only decoded when EXECUTE_MUL_EN is defined.
package exec_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1011;

    localparam logic [2:0] BR_NONE  = 3'b000;
    localparam logic [2:0] BR_BEQ   = 3'b001;
    localparam logic [2:0] BR_BNE   = 3'b010;
    localparam logic [2:0] BR_BLT   = 3'b011;
    localparam logic [2:0] BR_BGE   = 3'b100;
    localparam logic [2:0] BR_BLTU  = 3'b101;
    localparam logic [2:0] BR_BGEU  = 3'b110;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage, plus eq/lt/ltu compare flags on (SrcA, cmp_b).
// Optional MUL op (code 1011) is built only when EXECUTE_MUL_EN is defined.
module alu_unit
    import exec_pkg::*;
(
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic [XLEN-1:0] cmp_b_i,
    input  logic [3:0]      alu_ctrl_i,
    output logic [XLEN-1:0] result_o,
    output logic            eq_o,
    output logic            lt_o,
    output logic            ltu_o
);

    logic [4:0] shamt;
    logic       slt_bit;
    logic       sltu_bit;

    assign shamt    = src_b_i[4:0];
    assign slt_bit  = $signed(src_a_i) < $signed(src_b_i);
    assign sltu_bit = src_a_i < src_b_i;

    // Branch flags compare against the forwarded register value, never the immediate.
    assign eq_o  = src_a_i == cmp_b_i;
    assign lt_o  = $signed(src_a_i) < $signed(cmp_b_i);
    assign ltu_o = src_a_i < cmp_b_i;

    always_comb begin
        result_o = '0;
        case (alu_ctrl_i)
            ALU_ADD:  result_o = src_a_i + src_b_i;
            ALU_SUB:  result_o = src_a_i - src_b_i;
            ALU_AND:  result_o = src_a_i & src_b_i;
            ALU_OR:   result_o = src_a_i | src_b_i;
            ALU_XOR:  result_o = src_a_i ^ src_b_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, slt_bit};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, sltu_bit};
            ALU_SLL:  result_o = src_a_i << shamt;
            ALU_SRL:  result_o = src_a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(src_a_i) >>> shamt);
            ALU_LUI:  result_o = src_b_i;
`ifdef EXECUTE_MUL_EN
            ALU_MUL:  result_o = src_a_i * src_b_i;
`endif
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: forwarding muxes, ALU, branch resolution and the EX/MEM register.
// Define EXECUTE_MUL_EN to enable the MUL ALU op (see alu_unit).
module execute_cycle #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  RegWriteE,
    input  logic                  ALUSrcE,
    input  logic                  MemWriteE,
    input  logic                  JumpE,
    input  logic [1:0]            ResultSrcE,
    input  logic [2:0]            BranchE,
    input  logic [3:0]            ALUControlE,
    input  logic [XLEN-1:0]       RD1_E,
    input  logic [XLEN-1:0]       RD2_E,
    input  logic [XLEN-1:0]       Imm_Ext_E,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [XLEN-1:0]       ResultW,
    input  logic [1:0]            ForwardA_E,
    input  logic [1:0]            ForwardB_E,
    input  logic                  StallM,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [XLEN-1:0]       PCPlus4M
);

    import exec_pkg::*;

    logic [XLEN-1:0]       src_a, fwd_b, src_b, alu_result;
    logic                  eq, lt, ltu, taken;

    logic                  reg_write_q, mem_write_q;
    logic [1:0]            result_src_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       alu_result_q, write_data_q, pc_plus4_q;

    // Code 11 falls back to the register-file value.
    always_comb begin
        case (ForwardA_E)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = alu_result_q;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    alu_unit u_alu (
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .cmp_b_i    (fwd_b),
        .alu_ctrl_i (ALUControlE),
        .result_o   (alu_result),
        .eq_o       (eq),
        .lt_o       (lt),
        .ltu_o      (ltu)
    );

    always_comb begin
        taken = 1'b0;
        case (BranchE)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = ~eq;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = ~lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE    = JumpE | taken;
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM boundary: held while StallM, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else if (!StallM) begin
            reg_write_q  <= RegWriteE;
            mem_write_q  <= MemWriteE;
            result_src_q <= ResultSrcE;
            rd_q         <= RD_E;
            alu_result_q <= alu_result;
            write_data_q <= fwd_b;
            pc_plus4_q   <= PCPlus4E;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline, directly downstream of the decode stage's ID/EX register.
- Selects operands through forwarding muxes, runs the ALU and evaluates branches.
- Drives the PC redirect (PCSrcE/PCTargetE) back to fetch.
- Registers results into the EX/MEM pipeline register consumed by the memory stage.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- RegWriteE, ALUSrcE, MemWriteE, JumpE  in  1 each  control from ID/EX
- ResultSrcE  in  2  writeback select
- BranchE  in  3  branch type
- ALUControlE  in  4  ALU op
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  ID/EX data
- RD_E  in  5  destination register
- ResultW  in  32  writeback-stage result (forward source)
- ForwardA_E, ForwardB_E  in  2 each  forwarding selects from the hazard unit
- StallM  in  1  hold EX/MEM register
- PCSrcE  out  1  redirect PC (combinational)
- PCTargetE  out  32  PCE + Imm_Ext_E (combinational)
- RegWriteM, MemWriteM  out  1 each
- ResultSrcM  out  2
- RD_M  out  5
- ALUResultM, WriteDataM, PCPlus4M  out  32 each

Behaviour:
- Forward mux A/B:
  - 00: RD1_E / RD2_E
  - 01: ResultW
  - 10: ALUResultM (internal feedback of the registered value)
  - 11: treated as 00
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B. WriteData = forwarded B (never the immediate).
- ALU ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 pass SrcB (LUI). Undefined codes give 0.
- Shift amount = SrcB[4:0]. All arithmetic is modulo 2^32; no overflow flag.
- Branch compare uses the forwarded A and forwarded B, never the immediate.
- BranchE encoding: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 never taken.
- PCSrcE = JumpE | taken. JumpE with a nonzero BranchE is still taken (jump wins).
- PCTargetE = PCE + Imm_Ext_E, wrapping at 2^32. Both PCSrcE and PCTargetE are purely combinational: zero-cycle latency to fetch.
- EX/MEM register: single-cycle latency, captured on the rising edge of clock.
- StallM=1 holds every M output. Feedback path 10 then keeps supplying the held ALUResultM.
- reset low (asynchronous, any time, including mid-stream): all M outputs clear to 0 immediately. PCSrcE still follows its inputs combinationally; the upstream ID/EX reset forces its inputs to 0, so PCSrcE is 0 then.
- Release of reset: the first capture occurs on the first rising edge after reset goes high.

Optional Feature:
- Macro EXECUTE_MUL_EN.
- Defined: ALUControl 1011 = MUL, low 32 bits of SrcA*SrcB, single cycle.
- Undefined: 1011 is an undefined code and yields 0. No multiplier is inferred.

Decomposition:
- Package exec_pkg holds:
  - ALU op localparams (ALU_ADD … ALU_MUL)
  - branch type codes (BR_NONE … BR_BGEU)
  - forward select codes (FWD_RF, FWD_WB, FWD_MEM)
  - XLEN
- One sub-module, alu_unit: combinational SrcA/SrcB/ALUControl → result, also providing eq/lt/ltu flags reused by the branch logic.
- Forwarding muxes, branch decision and EX/MEM register live in the top module.

Test Plan:
- ADD fwd: RD1_E=5, RD2_E=7, ALUControl 0000, fwd 00/00 → ALUResultM=12 after 1 edge. Repeat with ForwardA_E=01, ResultW=100 → 107. Repeat with ForwardB_E=10 taking previous ALUResultM=12, A=5 → 17.
- Branch signed vs unsigned: A=0xFFFFFFFF, B=1:
  - BLT → PCSrcE=1
  - BLTU → PCSrcE=0
  - BEQ with A=B=3 → 1
  - PCE=0x100, Imm=0xFFFFFFF8 → PCTargetE=0xF8
- Shifts/compare: A=0x80000000, SrcB imm=4:
  - SRA → 0xF8000000
  - SRL → 0x08000000
  - SLT(A, 1) → 1
  - SLTU → 0
- Store path: ALUSrcE=1, Imm=8, RD2_E=0xDEADBEEF, MemWriteE=1 → WriteDataM=0xDEADBEEF, ALUResultM=RD1_E+8, MemWriteM=1.
- StallM=1 for 3 cycles while inputs change → all M outputs constant. Release → next edge captures the current inputs.
- Async reset mid-stream: assert reset low between edges → all M outputs 0 before the next edge. Deassert → normal capture resumes.
- With EXECUTE_MUL_EN defined: ALUControl 1011, A=0x10000, B=0x10001 → ALUResultM=0x00010000 (low word of 0x1_0001_0000). Without the macro → 0.
